cordic_rot_seq: RTL and testbench

- Iterative CORDIC rotation-mode engine holding X, Y and Z in sign-magnitude form.
- Performs one micro-rotation per clock and drives three sign-magnitude add/sub operations per iteration, with the same sign/AS semantics as the datapath adder.
- Sits directly upstream of, and wraps, the sign-magnitude adders; accepts one vector plus angle and returns the rotated vector and residual angle.

---
 rtl/cordic_pkg.sv | 36 +++
 rtl/sm_addsub.sv | 44 ++++
 rtl/cordic_rot_seq.sv | 146 ++++++++++++++
 tb/tb_cordic_rot_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the sequential CORDIC rotator: default width,
// controller states and the arctangent table in angle LSBs (2^-14 rad).
package cordic_pkg;

    localparam int unsigned DEF_MAG_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [15:0] atan_lsb(input int unsigned idx);
        logic [15:0] val;
        case (idx)
            0:       val = 16'd12868;
            1:       val = 16'd7596;
            2:       val = 16'd4014;
            3:       val = 16'd2037;
            4:       val = 16'd1023;
            5:       val = 16'd512;
            6:       val = 16'd256;
            7:       val = 16'd128;
            8:       val = 16'd64;
            9:       val = 16'd32;
            10:      val = 16'd16;
            11:      val = 16'd8;
            12:      val = 16'd4;
            13:      val = 16'd2;
            14:      val = 16'd1;
            default: val = 16'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/sm_addsub.sv
// Combinational sign-magnitude add/subtract (sub=1 computes a - b) with
// magnitude saturation on carry-out and a canonical +0 result.
module sm_addsub #(
    parameter int unsigned MAG_W = 16
) (
    input  logic             a_sign,
    input  logic [MAG_W-1:0] a_mag,
    input  logic             b_sign,
    input  logic [MAG_W-1:0] b_mag,
    input  logic             sub,
    output logic             r_sign,
    output logic [MAG_W-1:0] r_mag,
    output logic             ovf
);

    logic             b_eff_sign;
    logic [MAG_W:0]   sum;

    assign b_eff_sign = b_sign ^ sub;
    assign sum        = {1'b0, a_mag} + {1'b0, b_mag};

    always_comb begin
        r_sign = a_sign;
        r_mag  = '0;
        ovf    = 1'b0;
        if (a_sign == b_eff_sign) begin
            if (sum[MAG_W]) begin
                r_mag = '1;
                ovf   = 1'b1;
            end else begin
                r_mag = sum[MAG_W-1:0];
            end
        end else if (a_mag >= b_mag) begin
            r_mag = a_mag - b_mag;
        end else begin
            r_mag  = b_mag - a_mag;
            r_sign = b_eff_sign;
        end
        if (r_mag == '0) begin
            r_sign = 1'b0;
        end
    end

endmodule

// File: rtl/cordic_rot_seq.sv
// Iterative CORDIC rotation-mode engine: one micro-rotation per clock on
// sign-magnitude X/Y/Z registers, valid/ready result handshake.
import cordic_pkg::*;

module cordic_rot_seq #(
    parameter int unsigned MAG_W = DEF_MAG_W,
    parameter int unsigned ITERS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    input  logic             x_in_sign,
    input  logic             y_in_sign,
    input  logic             z_in_sign,
    input  logic [MAG_W-1:0] x_in,
    input  logic [MAG_W-1:0] y_in,
    input  logic [MAG_W-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             x_out_sign,
    output logic             y_out_sign,
    output logic             z_out_sign,
    output logic [MAG_W-1:0] x_out,
    output logic [MAG_W-1:0] y_out,
    output logic [MAG_W-1:0] z_out,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_sign_q, x_sign_d, y_sign_q, y_sign_d, z_sign_q, z_sign_d;
    logic [MAG_W-1:0] x_mag_q, x_mag_d, y_mag_q, y_mag_d, z_mag_q, z_mag_d;
    logic             ovf_q, ovf_d;

    logic             d_neg;
    logic [MAG_W-1:0] x_shr, y_shr, atan_i;
    logic             x_nsign, y_nsign, z_nsign;
    logic [MAG_W-1:0] x_nmag, y_nmag, z_nmag;
    logic             x_ovf, y_ovf, z_ovf;

    assign d_neg  = z_sign_q & (|z_mag_q);
    assign x_shr  = x_mag_q >> cnt_q;
    assign y_shr  = y_mag_q >> cnt_q;
    assign atan_i = MAG_W'(atan_lsb(32'(cnt_q)));

    // d positive: X -= Ys, Y += Xs, Z -= atan; d negative flips every operation.
    sm_addsub #(.MAG_W(MAG_W)) u_add_x (
        .a_sign(x_sign_q), .a_mag(x_mag_q), .b_sign(y_sign_q), .b_mag(y_shr),
        .sub(~d_neg), .r_sign(x_nsign), .r_mag(x_nmag), .ovf(x_ovf)
    );
    sm_addsub #(.MAG_W(MAG_W)) u_add_y (
        .a_sign(y_sign_q), .a_mag(y_mag_q), .b_sign(x_sign_q), .b_mag(x_shr),
        .sub(d_neg), .r_sign(y_nsign), .r_mag(y_nmag), .ovf(y_ovf)
    );
    sm_addsub #(.MAG_W(MAG_W)) u_add_z (
        .a_sign(z_sign_q), .a_mag(z_mag_q), .b_sign(1'b0), .b_mag(atan_i),
        .sub(~d_neg), .r_sign(z_nsign), .r_mag(z_nmag), .ovf(z_ovf)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_sign_d = x_sign_q;
        y_sign_d = y_sign_q;
        z_sign_d = z_sign_q;
        x_mag_d  = x_mag_q;
        y_mag_d  = y_mag_q;
        z_mag_d  = z_mag_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_sign_d = x_in_sign & (|x_in);
                    y_sign_d = y_in_sign & (|y_in);
                    z_sign_d = z_in_sign & (|z_in);
                    x_mag_d  = x_in;
                    y_mag_d  = y_in;
                    z_mag_d  = z_in;
                    ovf_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Counter reaching ITERS is a hand-off cycle with no update,
                // giving the ITERS+1 cycle start-to-valid latency.
                if (cnt_q == CNT_W'(ITERS)) begin
                    state_d = ST_DONE;
                end else begin
                    x_sign_d = x_nsign;
                    y_sign_d = y_nsign;
                    z_sign_d = z_nsign;
                    x_mag_d  = x_nmag;
                    y_mag_d  = y_nmag;
                    z_mag_d  = z_nmag;
                    ovf_d    = ovf_q | x_ovf | y_ovf | z_ovf;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            x_sign_q <= 1'b0;
            y_sign_q <= 1'b0;
            z_sign_q <= 1'b0;
            x_mag_q  <= '0;
            y_mag_q  <= '0;
            z_mag_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_sign_q <= x_sign_d;
            y_sign_q <= y_sign_d;
            z_sign_q <= z_sign_d;
            x_mag_q  <= x_mag_d;
            y_mag_q  <= y_mag_d;
            z_mag_q  <= z_mag_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign x_out_sign = x_sign_q;
    assign y_out_sign = y_sign_q;
    assign z_out_sign = z_sign_q;
    assign x_out      = x_mag_q;
    assign y_out      = y_mag_q;
    assign z_out      = z_mag_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_cordic_rot_seq.sv
// Randomized and directed bench for cordic_rot_seq against a signed-integer
// CORDIC reference model with magnitude clipping.
module tb_cordic_rot_seq;

    localparam int MW  = 16;
    localparam int IT  = 16;
    localparam int LIM = 65535;

    logic        clock = 1'b0;
    logic        reset, start, busy, out_valid, out_ready, ovf;
    logic        x_in_sign, y_in_sign, z_in_sign;
    logic [15:0] x_in, y_in, z_in;
    logic        x_out_sign, y_out_sign, z_out_sign;
    logic [15:0] x_out, y_out, z_out;

    int vectors     = 0;
    int miscompares = 0;
    int atan_t [16] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128,
                        64, 32, 16, 8, 4, 2, 1, 0};

    always #5 clock = ~clock;

    cordic_rot_seq #(.MAG_W(MW), .ITERS(IT)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy),
        .x_in_sign(x_in_sign), .y_in_sign(y_in_sign), .z_in_sign(z_in_sign),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out_sign(x_out_sign), .y_out_sign(y_out_sign), .z_out_sign(z_out_sign),
        .x_out(x_out), .y_out(y_out), .z_out(z_out), .ovf(ovf)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int smv(input logic s, input logic [15:0] m);
        return s ? -int'(m) : int'(m);
    endfunction

    function automatic int shr_sm(input int v, input int i);
        return (v < 0) ? -((-v) >> i) : (v >> i);
    endfunction

    function automatic int clip(input int v);
        if (v > LIM) return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    // Plain signed arithmetic: rotate by the sign of the residual angle.
    task automatic ref_rotate(input int x0, input int y0, input int z0,
                              output int xr, output int yr, output int zr, output int ov);
        int x, y, z;
        x = x0; y = y0; z = z0; ov = 0;
        for (int i = 0; i < IT; i++) begin
            int d, nx, ny, nz;
            d  = (z >= 0) ? 1 : -1;
            nx = x - d * shr_sm(y, i);
            ny = y + d * shr_sm(x, i);
            nz = z - d * atan_t[i];
            if (nx != clip(nx) || ny != clip(ny) || nz != clip(nz)) ov = 1;
            x = clip(nx); y = clip(ny); z = clip(nz);
        end
        xr = x; yr = y; zr = z;
    endtask

    task automatic check_out(input string p, input int ex, input int ey, input int ez, input int eov);
        check_eq({p, ".xs"}, x_out_sign, ex < 0);
        check_eq({p, ".xm"}, x_out, iabs(ex));
        check_eq({p, ".ys"}, y_out_sign, ey < 0);
        check_eq({p, ".ym"}, y_out, iabs(ey));
        check_eq({p, ".zs"}, z_out_sign, ez < 0);
        check_eq({p, ".zm"}, z_out, iabs(ez));
        check_eq({p, ".ovf"}, ovf, eov);
    endtask

    task automatic do_vec(input string tag, input bit xs, input int xm, input bit ys, input int ym,
                          input bit zs, input int zm, input int hold);
        int ex, ey, ez, eov, cyc;
        ref_rotate(xs ? -xm : xm, ys ? -ym : ym, zs ? -zm : zm, ex, ey, ez, eov);
        @(negedge clock);
        x_in_sign = xs; x_in = 16'(xm);
        y_in_sign = ys; y_in = 16'(ym);
        z_in_sign = zs; z_in = 16'(zm);
        start = 1'b1;
        out_ready = (hold == 0);
        @(negedge clock);
        start = 1'b0;
        check_eq({tag, ".busy"}, busy, 1);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check_eq({tag, ".lat"}, cyc, IT + 1);
        check_out(tag, ex, ey, ez, eov);
        for (int k = 0; k < hold; k++) begin
            start = (k == 1);
            if (k == 1) begin
                x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
            end
            @(negedge clock);
            check_eq({tag, ".hold_v"}, out_valid, 1);
            check_eq({tag, ".hold_y"}, smv(y_out_sign, y_out), ey);
        end
        if (hold > 0) begin
            out_ready = 1'b1;
            start = 1'b1;
        end
        @(negedge clock);
        start = 1'b0;
        check_eq({tag, ".idle_busy"}, busy, 0);
        check_eq({tag, ".idle_v"}, out_valid, 0);
        check_eq({tag, ".keep_x"}, smv(x_out_sign, x_out), ex);
        check_eq({tag, ".keep_z"}, smv(z_out_sign, z_out), ez);
    endtask

    initial begin
        int vcount;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        x_in_sign = 1'b0; y_in_sign = 1'b0; z_in_sign = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst.busy", busy, 0);
        check_eq("rst.valid", out_valid, 0);
        check_out("rst", 0, 0, 0, 0);

        do_vec("r45", 1'b0, 9949, 1'b0, 0, 1'b0, 12868, 0);
        check_eq("r45.x_near", iabs(smv(x_out_sign, x_out) - 11585) <= 16, 1);
        check_eq("r45.y_near", iabs(smv(y_out_sign, y_out) - 11585) <= 16, 1);
        check_eq("r45.z_small", z_out <= 16, 1);

        do_vec("rm90", 1'b0, 9949, 1'b0, 0, 1'b1, 25736, 0);
        check_eq("rm90.x_near", iabs(smv(x_out_sign, x_out)) <= 16, 1);
        check_eq("rm90.y_near", iabs(smv(y_out_sign, y_out) + 16384) <= 16, 1);
        check_eq("rm90.y_neg", y_out_sign, 1);

        do_vec("bp", 1'b0, 12000, 1'b1, 3000, 1'b0, 5000, 5);
        do_vec("after_bp", 1'b1, 7000, 1'b0, 7000, 1'b1, 9000, 0);

        do_vec("sat", 1'b0, 65535, 1'b0, 65535, 1'b0, 12868, 0);
        check_eq("sat.ovf_set", ovf, 1);

        do_vec("zero", 1'b1, 0, 1'b0, 0, 1'b0, 0, 0);
        check_eq("zero.x", {16'(x_out), 1'(x_out_sign)}, 0);
        check_eq("zero.y", {16'(y_out), 1'(y_out_sign)}, 0);

        for (int n = 0; n < 24; n++) begin
            int xm, ym;
            xm = (n % 6 == 5) ? $urandom_range(40000, 65535) : $urandom_range(0, 20000);
            ym = $urandom_range(0, 20000);
            do_vec($sformatf("rnd%0d", n), 1'($urandom), xm, 1'($urandom), ym,
                   1'($urandom), $urandom_range(0, 25736), $urandom_range(0, 3));
        end

        // Abort a run part-way through with reset.
        @(negedge clock);
        x_in_sign = 1'b0; x_in = 16'd30000; y_in_sign = 1'b1; y_in = 16'd20000;
        z_in_sign = 1'b0; z_in = 16'd9000; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("mid_rst.busy", busy, 0);
        check_eq("mid_rst.valid", out_valid, 0);
        check_out("mid_rst", 0, 0, 0, 0);
        vcount = 0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid) vcount++;
        end
        check_eq("mid_rst.no_valid", vcount, 0);

        do_vec("post_rst", 1'b0, 9949, 1'b0, 0, 1'b0, 12868, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
